// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel pipeline stages.
package vga_pkg;
  localparam int RGB_W = 12;
  localparam int HV_W  = 11;
  localparam logic [RGB_W-1:0] KEY_RGB_DEF = 12'hF0F;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_ge2(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction
endpackage

// File: rtl/delay.sv
// Fixed-latency register pipeline used to align timing/colour with ROM data.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  generate
    if (CLK_DEL == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [CLK_DEL];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign dout = pipe[CLK_DEL-1];
    end
  endgenerate
endmodule

// File: rtl/sprite_hit.sv
// Per-sprite frame-latched position, half-open box test and ROM address.
module sprite_hit
  import vga_pkg::*;
#(
  parameter int COORD_W    = 12,
  parameter int SPR_W_LOG2 = 4,
  parameter int SPR_H_LOG2 = 4
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic                             boundary,
  input  logic [COORD_W-1:0]               xpos,
  input  logic [COORD_W-1:0]               ypos,
  input  logic                             en,
  input  logic [HV_W-1:0]                  hcount,
  input  logic [HV_W-1:0]                  vcount,
  output logic                             in_box,
  output logic [SPR_W_LOG2+SPR_H_LOG2-1:0] addr
);
  logic [COORD_W-1:0] x_sh, y_sh;
  logic               en_sh;

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_sh  <= '0;
      y_sh  <= '0;
      en_sh <= 1'b0;
    end else if (boundary) begin
      x_sh  <= xpos;
      y_sh  <= ypos;
      en_sh <= en;
    end
  end

  // One extra bit so the right/bottom edge never wraps back into range.
  logic [COORD_W:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
  assign h_ext = {{(COORD_W+1-HV_W){1'b0}}, hcount};
  assign v_ext = {{(COORD_W+1-HV_W){1'b0}}, vcount};
  assign x_ext = {1'b0, x_sh};
  assign y_ext = {1'b0, y_sh};
  assign x_end = x_ext + (COORD_W+1)'(1 << SPR_W_LOG2);
  assign y_end = y_ext + (COORD_W+1)'(1 << SPR_H_LOG2);

  assign in_box = en_sh && (h_ext >= x_ext) && (h_ext < x_end)
                        && (v_ext >= y_ext) && (v_ext < y_end);

  logic [SPR_W_LOG2-1:0] col;
  logic [SPR_H_LOG2-1:0] row;
  assign col  = hcount[SPR_W_LOG2-1:0] - x_sh[SPR_W_LOG2-1:0];
  assign row  = vcount[SPR_H_LOG2-1:0] - y_sh[SPR_H_LOG2-1:0];
  assign addr = rst ? '0 : {row, col};
endmodule

// File: rtl/vga_draw_sprites.sv
// Multi-sprite overlay: colour-key transparency, index priority, per-frame collision flags.
module vga_draw_sprites
  import vga_pkg::*;
#(
  parameter int               N_SPR      = 2,
  parameter int               SPR_W_LOG2 = 4,
  parameter int               SPR_H_LOG2 = 4,
  parameter int               ROM_LAT    = 1,
  parameter logic [RGB_W-1:0] KEY_RGB    = KEY_RGB_DEF,
  parameter int               COORD_W    = 12
) (
  input  logic                                           pclk,
  input  logic                                           rst,
  input  logic [HV_W-1:0]                                hcount_in,
  input  logic                                           hsync_in,
  input  logic                                           hblnk_in,
  input  logic [HV_W-1:0]                                vcount_in,
  input  logic                                           vsync_in,
  input  logic                                           vblnk_in,
  input  logic [RGB_W-1:0]                               rgb_in,
  input  logic [N_SPR*COORD_W-1:0]                       xpos,
  input  logic [N_SPR*COORD_W-1:0]                       ypos,
  input  logic [N_SPR-1:0]                               spr_en,
  input  logic [N_SPR*RGB_W-1:0]                         rgb_pixel,
  output logic [N_SPR*(SPR_W_LOG2+SPR_H_LOG2)-1:0]       pixel_addr,
  output logic [HV_W-1:0]                                hcount_out,
  output logic                                           hsync_out,
  output logic                                           hblnk_out,
  output logic [HV_W-1:0]                                vcount_out,
  output logic                                           vsync_out,
  output logic                                           vblnk_out,
  output logic [RGB_W-1:0]                               rgb_out,
  output logic                                           collision,
  output logic [N_SPR-1:0]                               hit_mask
);
  localparam int AW = SPR_W_LOG2 + SPR_H_LOG2;
  localparam int DW = 38 + N_SPR;

  // Held high through reset so a reset inside vblank cannot fake a boundary.
  logic vblnk_prev, boundary;
  always_ff @(posedge pclk) begin
    if (rst) vblnk_prev <= 1'b1;
    else     vblnk_prev <= vblnk_in;
  end
  assign boundary = vblnk_in && !vblnk_prev;

  logic [N_SPR-1:0] in_box;
  generate
    for (genvar g = 0; g < N_SPR; g++) begin : g_spr
      sprite_hit #(
        .COORD_W   (COORD_W),
        .SPR_W_LOG2(SPR_W_LOG2),
        .SPR_H_LOG2(SPR_H_LOG2)
      ) u_hit (
        .pclk    (pclk),
        .rst     (rst),
        .boundary(boundary),
        .xpos    (xpos[g*COORD_W +: COORD_W]),
        .ypos    (ypos[g*COORD_W +: COORD_W]),
        .en      (spr_en[g]),
        .hcount  (hcount_in),
        .vcount  (vcount_in),
        .in_box  (in_box[g]),
        .addr    (pixel_addr[g*AW +: AW])
      );
    end
  endgenerate

  logic [DW-1:0]    dly_in, dly_out;
  logic [N_SPR-1:0] in_d;
  logic [RGB_W-1:0] rgb_d;
  logic [HV_W-1:0]  hcount_d, vcount_d;
  logic             hsync_d, hblnk_d, vsync_d, vblnk_d;

  assign dly_in = {in_box, rgb_in, hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
  assign {in_d, rgb_d, hcount_d, hsync_d, hblnk_d, vcount_d, vsync_d, vblnk_d} = dly_out;

  delay #(
    .WIDTH  (DW),
    .CLK_DEL(ROM_LAT)
  ) u_delay (
    .clk (pclk),
    .rst (rst),
    .din (dly_in),
    .dout(dly_out)
  );

  logic [N_SPR-1:0] opaque;
  logic [RGB_W-1:0] nxt;
  logic             blank_d;

  assign blank_d = hblnk_d || vblnk_d;

  // Descending scan so the lowest opaque index is the last (winning) write.
  always_comb begin
    opaque = '0;
    nxt    = rgb_d;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      opaque[i] = in_d[i] && (rgb_pixel[i*RGB_W +: RGB_W] != KEY_RGB);
      if (opaque[i]) nxt = rgb_pixel[i*RGB_W +: RGB_W];
    end
    if (blank_d) nxt = '0;
  end

  logic             acc_any;
  logic [N_SPR-1:0] acc_mask;

  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_out    <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      collision  <= 1'b0;
      hit_mask   <= '0;
      acc_any    <= 1'b0;
      acc_mask   <= '0;
    end else begin
      rgb_out    <= nxt;
      hcount_out <= hcount_d;
      hsync_out  <= hsync_d;
      hblnk_out  <= hblnk_d;
      vcount_out <= vcount_d;
      vsync_out  <= vsync_d;
      vblnk_out  <= vblnk_d;
      if (boundary) begin
        collision <= acc_any;
        hit_mask  <= acc_mask;
        acc_any   <= 1'b0;
        acc_mask  <= '0;
      end else if (!blank_d && popcount_ge2(8'(opaque))) begin
        acc_any  <= 1'b1;
        acc_mask <= acc_mask | opaque;
      end
    end
  end
endmodule

// File: tb/tb_vga_draw_sprites.sv
// Randomized scoreboard bench for vga_draw_sprites against a per-pixel reference model.
module tb_vga_draw_sprites;
  localparam int N = 2, SWL = 4, SHL = 4, LAT = 1, CW = 12, AW = 8;
  localparam int W = 16, H = 16;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam int HT = 40, HA = 32, VT = 30, VA = 24;
  localparam int FRAMES = 9;

  logic           pclk, rst;
  logic [10:0]    hcount_in, vcount_in, hcount_out, vcount_out;
  logic           hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic           hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0]    rgb_in, rgb_out;
  logic [N*CW-1:0] xpos, ypos;
  logic [N-1:0]   spr_en, hit_mask;
  logic [N*12-1:0] rgb_pixel;
  logic [N*AW-1:0] pixel_addr;
  logic           collision;

  vga_draw_sprites #(
    .N_SPR(N), .SPR_W_LOG2(SWL), .SPR_H_LOG2(SHL),
    .ROM_LAT(LAT), .KEY_RGB(KEY), .COORD_W(CW)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .spr_en(spr_en),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision(collision), .hit_mask(hit_mask)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    int          idx;
    logic [11:0] rgb;
    logic [10:0] h, v;
    logic        hs, hb, vs, vb;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int          pe = -1;
  logic        col_exp = 1'b0;
  logic [N-1:0] mask_exp = '0;

  logic [11:0] rom  [N][256];
  logic [7:0]  hist [N][LAT];

  int  hc = 0, vc = 0, frame = 0;
  int  lx[N], ly[N], sx[N], sy[N];
  bit  len[N], sen[N];
  bit  m_prev = 1'b1, acc_any = 1'b0;
  logic [N-1:0] acc_mask = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: sprite boxes, priority and collisions from plain integer geometry.
  task automatic model(input bit r, input int idx);
    exp_t        e;
    bit          blank;
    int          cnt;
    logic [N-1:0] ops;
    logic [11:0] p;
    if (r) begin
      m_prev = 1'b1;
      for (int s = 0; s < N; s++) sen[s] = 1'b0;
      acc_any = 1'b0; acc_mask = '0; col_exp = 1'b0; mask_exp = '0;
      return;
    end
    if (vblnk_in && !m_prev) begin
      col_exp = acc_any; mask_exp = acc_mask;
      acc_any = 1'b0; acc_mask = '0;
      for (int s = 0; s < N; s++) begin sx[s] = lx[s]; sy[s] = ly[s]; sen[s] = len[s]; end
    end
    m_prev = vblnk_in;
    blank = hblnk_in || vblnk_in;
    e.idx = idx; e.rgb = rgb_in;
    e.h = hcount_in; e.v = vcount_in;
    e.hs = hsync_in; e.hb = hblnk_in; e.vs = vsync_in; e.vb = vblnk_in;
    cnt = 0; ops = '0;
    for (int s = N - 1; s >= 0; s--) begin
      if (sen[s] && hc >= sx[s] && hc < sx[s] + W && vc >= sy[s] && vc < sy[s] + H) begin
        p = rom[s][((vc - sy[s]) % H) * W + ((hc - sx[s]) % W)];
        if (p != KEY) begin
          e.rgb = p; cnt++; ops[s] = 1'b1;
        end
      end
    end
    if (blank) e.rgb = '0;
    else if (cnt >= 2) begin acc_any = 1'b1; acc_mask = acc_mask | ops; end
    sb.push_back(e);
  endtask

  task automatic drive_live();
    for (int s = 0; s < N; s++) begin
      xpos[s*CW +: CW] = CW'(lx[s]);
      ypos[s*CW +: CW] = CW'(ly[s]);
      spr_en[s]        = len[s];
    end
  endtask

  task automatic cycle(input bit r);
    int idx;
    @(negedge pclk);
    rst = r;
    idx = pe + 1;
    hcount_in = 11'(hc); vcount_in = 11'(vc);
    hblnk_in = (hc >= HA); hsync_in = (hc >= 34 && hc < 36);
    vblnk_in = (vc >= VA); vsync_in = (vc >= 26 && vc < 28);
    rgb_in = 12'($urandom());
    for (int s = 0; s < N; s++) rgb_pixel[s*12 +: 12] = rom[s][hist[s][LAT-1]];
    drive_live();
    model(r, idx);
    if (hc == HT - 1) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end else hc++;
    #4;
    for (int s = 0; s < N; s++) begin
      for (int j = LAT - 1; j > 0; j--) hist[s][j] = hist[s][j-1];
      hist[s][0] = pixel_addr[s*AW +: AW];
    end
  endtask

  task automatic set_plan(input int f);
    case (f)
      0: begin lx = '{4, 4};  ly = '{3, 3};  len = '{1, 1}; end
      1: begin lx = '{0, 20}; ly = '{0, 12}; len = '{1, 1}; end
      2: begin lx = '{24, 24}; ly = '{16, 16}; len = '{1, 0}; end
      default: for (int s = 0; s < N; s++) begin
        lx[s] = $urandom_range(0, 40); ly[s] = $urandom_range(0, 30);
        len[s] = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  // Monitor: output at posedge p reflects inputs sampled at posedge p-LAT.
  initial begin
    int   last_rst = -100;
    exp_t e;
    forever begin
      @(posedge pclk);
      pe++;
      #1;
      if (rst) begin
        last_rst = pe;
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_col", 32'(collision), 32'h0);
        chk("rst_mask", 32'(hit_mask), 32'h0);
        chk("rst_hcount", 32'(hcount_out), 32'h0);
        chk("rst_addr", 32'(pixel_addr), 32'h0);
      end else begin
        chk("collision", 32'(collision), 32'(col_exp));
        chk("hit_mask", 32'(hit_mask), 32'(mask_exp));
        while (sb.size() > 0 && sb[0].idx < pe - LAT) void'(sb.pop_front());
        if (sb.size() > 0 && sb[0].idx == pe - LAT) begin
          e = sb.pop_front();
          if (last_rst <= e.idx) begin
            chk("rgb", 32'(rgb_out), 32'(e.rgb));
            chk("hcount", 32'(hcount_out), 32'(e.h));
            chk("vcount", 32'(vcount_out), 32'(e.v));
            chk("syncblnk", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}),
                32'({e.hs, e.hb, e.vs, e.vb}));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
    vsync_in = 0; vblnk_in = 0; rgb_in = '0; rgb_pixel = '0;
    xpos = '0; ypos = '0; spr_en = '0;
    for (int s = 0; s < N; s++) begin
      for (int a = 0; a < 256; a++)
        rom[s][a] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom());
      for (int j = 0; j < LAT; j++) hist[s][j] = '0;
    end
    for (int a = 0; a < W; a++) rom[0][a] = KEY;
    lx = '{3, 10}; ly = '{2, 6}; len = '{1, 1};
    repeat (3) cycle(1'b1);
    while (frame < FRAMES) begin
      bit r;
      r = (frame == 0 && vc == 5 && hc >= 10 && hc < 13);
      if (hc == 5 && vc == 10) set_plan(frame);
      cycle(r);
      if (hc == 0 && vc == 0) frame++;
    end
    repeat (LAT + 3) cycle(1'b0);
    chk("sb_pending", 32'(sb.size() <= LAT + 2), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
